onehot_checker: RTL and testbench

Parametrised one-hot validity checker for an N-bit vector, the sequential successor to the two-input OR gate. Each valid sample is classified on a clock edge as zero, one-hot or multi-hot, with registered reduction-OR and index outputs. Error statistics are kept for status readback: a sticky flag, a saturating error counter and a consecutive-error alarm. It sits on any one-hot select or grant bus, such as arbiter grants or mux selects, as a non-intrusive monitor.

---
 rtl/onehot_checker.sv | 136 +++++++++++++
 tb/tb_onehot_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_checker.sv
// rtl/onehot_checker.sv - one-hot validity checker with registered classification and error statistics
// Classifies each valid sample as zero, one-hot or multi-hot and tracks error count, run length and alarm.
module onehot_checker #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 8,
  parameter int THRESH     = 4,
  parameter int ALLOW_ZERO = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_vec,
  input  logic                     clr,
  output logic                     out_valid,
  output logic                     z,
  output logic                     zero,
  output logic                     onehot,
  output logic                     multi,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     err,
  output logic                     err_sticky,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     alarm
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic ZERO_IS_ERR = (ALLOW_ZERO == 0);

  logic             out_valid_q, out_valid_d;
  logic             z_q, z_d, zero_q, zero_d, onehot_q, onehot_d, multi_q, multi_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d, err_sticky_q, err_sticky_d, alarm_q, alarm_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, run_q, run_d;

  logic             any_set, many_set, c_zero, c_onehot, c_err;
  logic [IDX_W-1:0] pos;

  // A second set bit seen after the first one marks the vector as multi-hot.
  always_comb begin
    any_set  = 1'b0;
    many_set = 1'b0;
    pos      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_vec[i]) begin
        if (any_set) many_set = 1'b1;
        any_set = 1'b1;
        pos     = IDX_W'(i);
      end
    end
    c_zero   = ~any_set;
    c_onehot = any_set & ~many_set;
    c_err    = many_set | (c_zero & ZERO_IS_ERR);
  end

  always_comb begin
    out_valid_d  = in_valid;
    z_d          = z_q;
    zero_d       = zero_q;
    onehot_d     = onehot_q;
    multi_d      = multi_q;
    idx_d        = idx_q;
    err_d        = err_q;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    run_d        = run_q;
    alarm_d      = alarm_q;

    if (in_valid) begin
      z_d      = any_set;
      zero_d   = c_zero;
      onehot_d = c_onehot;
      multi_d  = many_set;
      idx_d    = c_onehot ? pos : '0;
      err_d    = c_err;
    end

    // clr wins over statistics updates but not over the result fields above.
    if (clr) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
      run_d        = '0;
      alarm_d      = 1'b0;
    end else if (in_valid) begin
      if (c_err) begin
        err_sticky_d = 1'b1;
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
        if (run_q != CNT_MAX) run_d = run_q + 1'b1;
        if (run_d == THRESH_C) alarm_d = 1'b1;
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      z_q          <= 1'b0;
      zero_q       <= 1'b0;
      onehot_q     <= 1'b0;
      multi_q      <= 1'b0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      run_q        <= '0;
      alarm_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      z_q          <= z_d;
      zero_q       <= zero_d;
      onehot_q     <= onehot_d;
      multi_q      <= multi_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      run_q        <= run_d;
      alarm_q      <= alarm_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign z          = z_q;
  assign zero       = zero_q;
  assign onehot     = onehot_q;
  assign multi      = multi_q;
  assign idx        = idx_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_onehot_checker.sv
// tb/tb_onehot_checker.sv - scoreboard bench for onehot_checker in three parameter configurations
module tb_onehot_checker;

  typedef struct packed {
    logic       z;
    logic       zero;
    logic       onehot;
    logic       multi;
    logic [2:0] idx;
    logic       err;
    logic       sticky;
    logic [7:0] cnt;
    logic       alarm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
  logic [7:0] vec0 = '0, vec1 = '0, vec2 = '0;
  logic       clr0 = 1'b0, clr1 = 1'b0, clr2 = 1'b0;

  logic       ov0, z0, zero0, oh0, mu0, err0, st0, al0;
  logic [2:0] idx0;
  logic [7:0] cnt0;
  logic       ov1, z1, zero1, oh1, mu1, err1, st1, al1;
  logic [2:0] idx1;
  logic [7:0] cnt1;
  logic       ov2, z2, zero2, oh2, mu2, err2, st2, al2;
  logic [2:0] idx2;
  logic [2:0] cnt2;

  onehot_checker #(.WIDTH(8), .CNT_W(8), .THRESH(4), .ALLOW_ZERO(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_vec(vec0), .clr(clr0),
    .out_valid(ov0), .z(z0), .zero(zero0), .onehot(oh0), .multi(mu0), .idx(idx0),
    .err(err0), .err_sticky(st0), .err_cnt(cnt0), .alarm(al0));

  onehot_checker #(.WIDTH(8), .CNT_W(8), .THRESH(4), .ALLOW_ZERO(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_vec(vec1), .clr(clr1),
    .out_valid(ov1), .z(z1), .zero(zero1), .onehot(oh1), .multi(mu1), .idx(idx1),
    .err(err1), .err_sticky(st1), .err_cnt(cnt1), .alarm(al1));

  onehot_checker #(.WIDTH(8), .CNT_W(3), .THRESH(4), .ALLOW_ZERO(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_vec(vec2), .clr(clr2),
    .out_valid(ov2), .z(z2), .zero(zero2), .onehot(oh2), .multi(mu2), .idx(idx2),
    .err(err2), .err_sticky(st2), .err_cnt(cnt2), .alarm(al2));

  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;
  exp_t q0[$], q1[$], q2[$];
  exp_t last0 = '0, last1 = '0, last2 = '0;

  function automatic exp_t mk(input logic z, input logic zr, input logic oh, input logic mu,
                              input logic [2:0] ix, input logic er, input logic st,
                              input logic [7:0] cn, input logic al);
    exp_t e;
    e = '{z, zr, oh, mu, ix, er, st, cn, al};
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t a, input exp_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got z=%b zero=%b oh=%b multi=%b idx=%0d err=%b sticky=%b cnt=%0d alarm=%b, expected z=%b zero=%b oh=%b multi=%b idx=%0d err=%b sticky=%b cnt=%0d alarm=%b",
               nm, a.z, a.zero, a.onehot, a.multi, a.idx, a.err, a.sticky, a.cnt, a.alarm,
               e.z, e.zero, e.onehot, e.multi, e.idx, e.err, e.sticky, e.cnt, e.alarm);
    end
  endtask

  task automatic cmp_bit(input string nm, input logic a, input logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  // Monitors: pop on out_valid, otherwise all result fields must hold the last popped value.
  always @(negedge clk) begin
    exp_t a;
    if (rst_n && mon_en) begin
      a = '{z0, zero0, oh0, mu0, idx0, err0, st0, cnt0, al0};
      if (ov0) begin
        if (q0.size() == 0) cmp_bit("dut0 unexpected out_valid", ov0, 1'b0);
        else begin last0 = q0.pop_front(); cmp("dut0 sample", a, last0); end
      end else cmp("dut0 hold", a, last0);
    end
  end

  always @(negedge clk) begin
    exp_t a;
    if (rst_n && mon_en) begin
      a = '{z1, zero1, oh1, mu1, idx1, err1, st1, cnt1, al1};
      if (ov1) begin
        if (q1.size() == 0) cmp_bit("dut1 unexpected out_valid", ov1, 1'b0);
        else begin last1 = q1.pop_front(); cmp("dut1 sample", a, last1); end
      end else cmp("dut1 hold", a, last1);
    end
  end

  always @(negedge clk) begin
    exp_t a;
    if (rst_n && mon_en) begin
      a = '{z2, zero2, oh2, mu2, idx2, err2, st2, {5'b0, cnt2}, al2};
      if (ov2) begin
        if (q2.size() == 0) cmp_bit("dut2 unexpected out_valid", ov2, 1'b0);
        else begin last2 = q2.pop_front(); cmp("dut2 sample", a, last2); end
      end else cmp("dut2 hold", a, last2);
    end
  end

  task automatic issue(input int d, input logic [7:0] v, input logic c, input exp_t e);
    case (d)
      0: begin iv0 = 1'b1; vec0 = v; clr0 = c; q0.push_back(e); end
      1: begin iv1 = 1'b1; vec1 = v; clr1 = c; q1.push_back(e); end
      default: begin iv2 = 1'b1; vec2 = v; clr2 = c; q2.push_back(e); end
    endcase
    @(posedge clk);
    #2;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_reset(input string nm);
    cmp(nm, '{z0, zero0, oh0, mu0, idx0, err0, st0, cnt0, al0}, '0);
    cmp(nm, '{z1, zero1, oh1, mu1, idx1, err1, st1, cnt1, al1}, '0);
    cmp(nm, '{z2, zero2, oh2, mu2, idx2, err2, st2, {5'b0, cnt2}, al2}, '0);
    cmp_bit(nm, ov0 | ov1 | ov2, 1'b0);
  endtask

  initial begin
    iv0 = 1'b1; iv1 = 1'b1; iv2 = 1'b1;
    vec0 = 8'hFF; vec1 = 8'hFF; vec2 = 8'hFF;
    repeat (3) @(negedge clk);
    check_reset("reset held");
    @(posedge clk);
    #2;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    rst_n = 1'b1;
    #1;
    check_reset("reset released");
    mon_en = 1'b1;

    // Sweep of every one-hot pattern, back to back.
    for (int i = 0; i < 8; i++)
      issue(0, 8'h01 << i, 1'b0, mk(1, 0, 1, 0, 3'(i), 0, 0, 8'd0, 0));
    idle(2);

    // Errors, a clean break, then a run of four errors.
    issue(0, 8'h00, 1'b0, mk(0, 1, 0, 0, 3'd0, 1, 1, 8'd1, 0));
    issue(0, 8'h03, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd2, 0));
    issue(0, 8'hFF, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd3, 0));
    issue(0, 8'h10, 1'b0, mk(1, 0, 1, 0, 3'd4, 0, 1, 8'd3, 0));
    issue(0, 8'h81, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd4, 0));
    issue(0, 8'h81, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd5, 0));
    issue(0, 8'h81, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd6, 0));
    issue(0, 8'h81, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd7, 1));
    idle(1);
    issue(0, 8'h01, 1'b0, mk(1, 0, 1, 0, 3'd0, 0, 1, 8'd7, 1));

    // clr with a clean sample, then rebuild err_cnt to 5 and collide clr with an error.
    issue(0, 8'h01, 1'b1, mk(1, 0, 1, 0, 3'd0, 0, 0, 8'd0, 0));
    issue(0, 8'h81, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd1, 0));
    issue(0, 8'h81, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd2, 0));
    issue(0, 8'h81, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd3, 0));
    issue(0, 8'h81, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd4, 1));
    issue(0, 8'h81, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd5, 1));
    issue(0, 8'h0C, 1'b1, mk(1, 0, 0, 1, 3'd0, 1, 0, 8'd0, 0));
    issue(0, 8'h0C, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd1, 0));
    idle(2);

    // All-zero is legal in this instance.
    issue(1, 8'h00, 1'b0, mk(0, 1, 0, 0, 3'd0, 0, 0, 8'd0, 0));
    issue(1, 8'h06, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, 8'd1, 0));
    issue(1, 8'h00, 1'b0, mk(0, 1, 0, 0, 3'd0, 0, 1, 8'd1, 0));
    idle(2);

    // 3-bit counter saturates at 7 with idle gaps between samples.
    for (int i = 1; i <= 10; i++) begin
      issue(2, 8'hC0, 1'b0, mk(1, 0, 0, 1, 3'd0, 1, 1, (i < 7) ? 8'(i) : 8'd7, (i >= 4)));
      idle(1);
    end
    idle(3);

    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_bad++;
      $display("FAIL pending results: got %0d outstanding expected 0", q0.size() + q1.size() + q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
